// File: rtl/mac_seq_pkg.sv
// Shared state encoding and default widths for the MAC sequencer.
package mac_seq_pkg;

    localparam int DATA_W_DEF  = 8;
    localparam int ACC_W_DEF   = 16;
    localparam int N_TERMS_DEF = 3;
    localparam int IDX_W_DEF   = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/mac_seq_unit.sv
// Multiply-accumulate datapath: combinational product, registered
// accumulator with synchronous clear, enable and sticky carry-out flag.
module mac_unit
    import mac_seq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [ACC_W-1:0]  acc,
    output logic              ovf
);

    logic [2*DATA_W-1:0] prod;
    logic [ACC_W-1:0]    prod_ext;
    logic [ACC_W:0]      sum;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic                ovf_q, ovf_d;

    // Full-width product fitted to the accumulator, then a carry-tracking add.
    always_comb begin
        prod     = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
        prod_ext = ACC_W'(prod);
        sum      = {1'b0, acc_q} + {1'b0, prod_ext};
        acc_d    = acc_q;
        ovf_d    = ovf_q;
        if (clr) begin
            acc_d = '0;
            ovf_d = 1'b0;
        end else if (en) begin
            acc_d = sum[ACC_W-1:0];
            ovf_d = ovf_q | sum[ACC_W];
        end
    end

    // Accumulator and overflow registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
        end
    end

    assign acc = acc_q;
    assign ovf = ovf_q;

endmodule

// File: rtl/mac_sequencer.sv
// Dot-product job controller driving one shared mac_unit.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | issuing operand reads, one index per cycle
// DRAIN | last operand pair arriving, accumulated on exit
// DONE  | result_valid held until the consumer accepts
module mac_sequencer
    import mac_seq_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ACC_W   = ACC_W_DEF,
    parameter int N_TERMS = N_TERMS_DEF,
    parameter int IDX_W   = IDX_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              rd_en,
    output logic [IDX_W-1:0]  rd_addr,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    output logic [ACC_W-1:0]  result,
    output logic              overflow,
    output logic              result_valid,
    input  logic              result_ready
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_TERMS - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             term_valid_q;
    logic             clr_acc;

    // Next-state, index and strobe decode.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        clr_acc      = 1'b0;
        busy         = 1'b0;
        rd_en        = 1'b0;
        result_valid = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    idx_d   = '0;
                    clr_acc = 1'b1;
                end
            end
            ST_RUN: begin
                busy  = 1'b1;
                rd_en = 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DRAIN;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_DRAIN: begin
                busy    = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                result_valid = 1'b1;
                if (result_ready) begin
                    if (start) begin
                        state_d = ST_RUN;
                        idx_d   = '0;
                        clr_acc = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, index and read-to-data alignment registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            term_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            term_valid_q <= rd_en;
        end
    end

    assign rd_addr = idx_q;

    mac_unit #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk   (clk),
        .reset (reset),
        .clr   (clr_acc),
        .en    (term_valid_q),
        .a     (a_in),
        .b     (b_in),
        .acc   (result),
        .ovf   (overflow)
    );

endmodule

// File: tb/tb_mac_sequencer.sv
// Self-checking bench for mac_sequencer (N_TERMS=3 main instance, N_TERMS=1 side instance).
module tb_mac_sequencer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic        reset, start, result_ready;
    logic        busy, rd_en, overflow, result_valid;
    logic [7:0]  rd_addr, a_in, b_in;
    logic [15:0] result;
    logic [7:0]  mem_a [256];
    logic [7:0]  mem_b [256];

    logic        start1, result_ready1;
    logic        busy1, rd_en1, overflow1, result_valid1;
    logic [7:0]  rd_addr1, a_in1, b_in1;
    logic [15:0] result1;
    logic [7:0]  mem1_a [256];
    logic [7:0]  mem1_b [256];

    mac_sequencer #(.DATA_W(8), .ACC_W(16), .N_TERMS(3), .IDX_W(8)) u_dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .rd_en(rd_en),
        .rd_addr(rd_addr), .a_in(a_in), .b_in(b_in), .result(result),
        .overflow(overflow), .result_valid(result_valid), .result_ready(result_ready)
    );

    mac_sequencer #(.DATA_W(8), .ACC_W(16), .N_TERMS(1), .IDX_W(8)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .busy(busy1), .rd_en(rd_en1),
        .rd_addr(rd_addr1), .a_in(a_in1), .b_in(b_in1), .result(result1),
        .overflow(overflow1), .result_valid(result_valid1), .result_ready(result_ready1)
    );

    // Operand stores with one-cycle read latency; junk when not read.
    always @(posedge clk) begin
        a_in  <= rd_en  ? mem_a[rd_addr]   : 8'($urandom);
        b_in  <= rd_en  ? mem_b[rd_addr]   : 8'($urandom);
        a_in1 <= rd_en1 ? mem1_a[rd_addr1] : 8'($urandom);
        b_in1 <= rd_en1 ? mem1_b[rd_addr1] : 8'($urandom);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: exact integer dot product; wraps mod 2^16, overflow iff it reached 2^16.
    function automatic longint model_sum(input int n);
        longint s = 0;
        for (int i = 0; i < n; i++) s += longint'(mem_a[i]) * longint'(mem_b[i]);
        return s;
    endfunction

    task automatic load3(input int a0, input int a1, input int a2,
                         input int b0, input int b1, input int b2);
        mem_a[0] = 8'(a0); mem_a[1] = 8'(a1); mem_a[2] = 8'(a2);
        mem_b[0] = 8'(b0); mem_b[1] = 8'(b1); mem_b[2] = 8'(b2);
    endtask

    task automatic start_job();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Entered in the first RUN cycle; leaves the DUT in DONE, unaccepted.
    task automatic run_body(input string tag, input bit poke_start);
        longint total = model_sum(3);
        for (int i = 0; i < 3; i++) begin
            chk({tag, ".rd_en"},   32'(rd_en), 32'd1);
            chk({tag, ".rd_addr"}, 32'(rd_addr), 32'(i));
            chk({tag, ".busy"},    32'(busy), 32'd1);
            chk({tag, ".valid_early"}, 32'(result_valid), 32'd0);
            if (poke_start && i == 1) start = 1'b1;
            tick();
            start = 1'b0;
        end
        chk({tag, ".drain_rd_en"}, 32'(rd_en), 32'd0);
        chk({tag, ".drain_busy"},  32'(busy), 32'd1);
        chk({tag, ".drain_valid"}, 32'(result_valid), 32'd0);
        tick();
        chk({tag, ".valid"},    32'(result_valid), 32'd1);
        chk({tag, ".done_busy"}, 32'(busy), 32'd0);
        chk({tag, ".result"},   32'(result), 32'(total % 65536));
        chk({tag, ".overflow"}, 32'(overflow), 32'(total >= 65536));
    endtask

    task automatic accept(input string tag);
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        chk({tag, ".valid_drop"}, 32'(result_valid), 32'd0);
        chk({tag, ".idle_busy"},  32'(busy), 32'd0);
    endtask

    initial begin
        logic [15:0] held_res;
        logic        held_ovf;
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 8'd0; mem_b[i] = 8'd0; mem1_a[i] = 8'd0; mem1_b[i] = 8'd0;
        end
        reset = 1'b1; start = 1'b0; result_ready = 1'b0;
        start1 = 1'b0; result_ready1 = 1'b0;
        tick();
        tick();
        chk("rst.busy",     32'(busy), 32'd0);
        chk("rst.rd_en",    32'(rd_en), 32'd0);
        chk("rst.valid",    32'(result_valid), 32'd0);
        chk("rst.overflow", 32'(overflow), 32'd0);
        chk("rst.rd_addr",  32'(rd_addr), 32'd0);
        chk("rst.result",   32'(result), 32'd0);
        reset = 1'b0;
        tick();

        // Nominal job.
        load3(1, 2, 3, 4, 5, 6);
        start_job();
        run_body("nom", 1'b0);
        chk("nom.result_32", 32'(result), 32'd32);
        accept("nom");

        // Overflow then a clean job.
        load3(255, 255, 255, 255, 255, 255);
        start_job();
        run_body("ovf", 1'b0);
        chk("ovf.result_64003", 32'(result), 32'd64003);
        chk("ovf.flag", 32'(overflow), 32'd1);
        accept("ovf");
        load3(1, 1, 1, 1, 1, 1);
        start_job();
        run_body("ovf_clr", 1'b0);
        chk("ovf_clr.flag", 32'(overflow), 32'd0);
        accept("ovf_clr");

        // Backpressure with start pulses in RUN and DONE.
        load3(1, 2, 3, 4, 5, 6);
        start_job();
        run_body("bp", 1'b1);
        held_res = result;
        held_ovf = overflow;
        for (int k = 0; k < 5; k++) begin
            start = (k == 2);
            tick();
            start = 1'b0;
            chk("bp.valid_hold",  32'(result_valid), 32'd1);
            chk("bp.result_hold", 32'(result), 32'(held_res));
            chk("bp.ovf_hold",    32'(overflow), 32'(held_ovf));
            chk("bp.no_rd_en",    32'(rd_en), 32'd0);
        end
        accept("bp");
        chk("bp.result_after_accept", 32'(result), 32'd32);
        tick();
        chk("bp.idle_rd_en", 32'(rd_en), 32'd0);
        chk("bp.idle_busy",  32'(busy), 32'd0);

        // Back-to-back: accept and start in the same DONE cycle.
        start_job();
        run_body("b2b_first", 1'b0);
        result_ready = 1'b1;
        start = 1'b1;
        tick();
        result_ready = 1'b0;
        start = 1'b0;
        chk("b2b.acc_cleared", 32'(result), 32'd0);
        chk("b2b.valid_drop",  32'(result_valid), 32'd0);
        run_body("b2b_second", 1'b0);
        chk("b2b.result_32", 32'(result), 32'd32);
        accept("b2b");

        // Reset mid-job.
        start_job();
        tick();
        chk("rstmid.rd_addr1", 32'(rd_addr), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rstmid.busy",   32'(busy), 32'd0);
        chk("rstmid.rd_en",  32'(rd_en), 32'd0);
        chk("rstmid.result", 32'(result), 32'd0);
        for (int k = 0; k < 6; k++) begin
            chk("rstmid.no_valid", 32'(result_valid), 32'd0);
            tick();
        end
        start_job();
        run_body("rstmid_after", 1'b0);
        chk("rstmid_after.result_32", 32'(result), 32'd32);
        accept("rstmid_after");

        // Randomized jobs with random acceptance delay.
        for (int j = 0; j < 20; j++) begin
            bit hi = 1'($urandom_range(0, 1));
            for (int i = 0; i < 3; i++) begin
                mem_a[i] = 8'(hi ? $urandom_range(200, 255) : $urandom_range(0, 255));
                mem_b[i] = 8'(hi ? $urandom_range(200, 255) : $urandom_range(0, 255));
            end
            start_job();
            run_body("rnd", 1'b0);
            held_res = result;
            for (int d = 0; d < int'($urandom_range(0, 3)); d++) begin
                tick();
                chk("rnd.hold", 32'(result), 32'(held_res));
            end
            accept("rnd");
        end

        // Single-term build.
        mem1_a[0] = 8'd7;
        mem1_b[0] = 8'd9;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("n1.rd_en",   32'(rd_en1), 32'd1);
        chk("n1.rd_addr", 32'(rd_addr1), 32'd0);
        tick();
        chk("n1.drain_rd_en", 32'(rd_en1), 32'd0);
        chk("n1.drain_busy",  32'(busy1), 32'd1);
        chk("n1.drain_valid", 32'(result_valid1), 32'd0);
        tick();
        chk("n1.valid",    32'(result_valid1), 32'd1);
        chk("n1.result",   32'(result1), 32'd63);
        chk("n1.overflow", 32'(overflow1), 32'd0);
        result_ready1 = 1'b1;
        tick();
        result_ready1 = 1'b0;
        chk("n1.valid_drop", 32'(result_valid1), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
